text_renderer: RTL and testbench
================================

TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 Parameter FG_COLOR, 16'hFFFF, RGB565 colour of a set glyph pixel.
REQ-002 Parameter BG_COLOR, 16'h0000, RGB565 colour of a clear glyph pixel.
REQ-003 Parameter BLINK_FRAMES, 32, number of frames per cursor blink half-period (range 1..255).
REQ-004 clk  in  1  pixel clock; the only clock.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 pix_x  in  10  current pixel column from the LCD timing generator.
REQ-007 pix_y  in  9  current pixel row from the LCD timing generator.
REQ-008 de_in / hs_in / vs_in  in  1 each  data-enable and syncs from the timing generator, aligned with pix_x and pix_y.
REQ-009 cursor_col  in  6, cursor_row  in  5  cursor cell position.
REQ-010 cursor_en  in  1  enables cursor display.
REQ-011 text_ad  out  12  text RAM address; text_ce  out  1  text RAM clock enable; text_dout  in  8  character code returned one clk after the address.
REQ-012 rgb  out  16  RGB565 pixel.
REQ-013 de_out / hs_out / vs_out  out  1 each  syncs delayed to match rgb.

Function
REQ-014 Screen geometry: 480x272 pixels, 8x16-pixel cells, 60 columns x 17 rows, text RAM row stride 64 bytes.
REQ-015 Cycle 0: drive text_ad = {pix_y[8:4] zero-extended to 6 bits, pix_x[8:3]}, combinationally from the inputs.
REQ-016 Cycle 0: drive text_ce = de_in.
REQ-017 Cycle 1: drive font ROM address = {text_dout, registered pix_y[3:0]} (12 bits).
REQ-018 Cycle 2: the font byte is valid; select bit (7 - pix_x[2:0]) using the delayed pix_x; MSB is the leftmost pixel.
REQ-019 Cycle 3: register rgb = bit ? FG_COLOR : BG_COLOR, XOR-inverted as a cell when the cursor is visible on that cell.
REQ-020 Fixed latency: 3 clk from inputs to rgb/de_out/hs_out/vs_out; the syncs pass through a 3-stage shift register.
REQ-021 When the delayed de is 0, rgb SHALL be 16'h0000 regardless of font data.
REQ-022 Cursor is visible when cursor_en=1, blink_phase=1, and the delayed cell column/row equal cursor_col/cursor_row.
REQ-023 A cursor_col >= 60 or cursor_row >= 17 never matches any cell, so no cursor is shown.
REQ-024 Blink counter: 8-bit frame counter increments on each rising edge of vs_in (edge detected against a registered vs_in).
REQ-025 On the rising-edge increment where the counter reaches BLINK_FRAMES-1, the counter wraps to 0 and blink_phase toggles.
REQ-026 cursor_col, cursor_row and cursor_en are sampled into the pipeline each cycle; a change takes effect on the next pixel with no tearing protection.
REQ-027 Cells whose pix_x lies in 480..1023 or whose pix_y lies in 272..511 are still addressed per REQ-015, but de_in is 0 there, so rgb is black (REQ-021).
REQ-028 The block performs no writes to text RAM; the text RAM write port belongs to the host writer.

Reset
REQ-029 While reset_n=0, these outputs SHALL be 0 immediately and asynchronously: rgb, de_out, hs_out, vs_out, text_ce, the pipeline registers, the frame counter, blink_phase, and the vs edge register.
REQ-030 After reset_n is released mid-frame, the first valid rgb appears 3 clk after the first de_in=1 sample; no stale pixels are emitted.

Structure
REQ-031 Shared package text_pkg SHALL hold CHAR_W=8, CHAR_H=16, COLS=60, ROWS=17, TEXT_STRIDE=64, and the RGB565 type/width constants.
REQ-032 One sub-module font_rom (4096x8 Gowin pROM wrapper, 1-clk registered read, 256 glyphs x 16 rows) SHALL be instantiated inside; the text RAM stays external.

Verification
REQ-033 Scenario: text RAM holds 8'h41 at address 0, font row 'A'/3 = 8'h18; drive pix_x=0..7, pix_y=3, de=1 -> rgb sequence BG,BG,BG,FG,FG,BG,BG,BG starting 3 clk later.
REQ-034 Scenario: pix_x=479, pix_y=271 -> text_ad=12'h43B (row 16, column 59); then de_in=0 -> rgb=0 with de_out=0 after 3 clk.
REQ-035 Scenario: BLINK_FRAMES=2, cursor at (col 1, row 0), cursor_en=1, apply 2 vs_in rising edges -> blink_phase=1 and cell (1,0) pixels are inverted (a space character renders FG); after 2 more edges the cell reverts.
REQ-036 Scenario: cursor_col=60, cursor_en=1, blink_phase=1 -> no pixel on the line is inverted.
REQ-037 Scenario: random hs/vs/de pattern -> de_out/hs_out/vs_out equal the inputs delayed by exactly 3 clk.
REQ-038 Scenario: assert reset_n=0 mid-line while de=1 -> rgb and de_out read 0 in the same cycle; after release, 3 clk of zeros, then correct pixels.

Source files
------------

// File: rtl/text_pkg.sv
// Shared geometry, colour types and sync bundle for the LCD text renderer.
package text_pkg;

  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int COLS        = 60;
  localparam int ROWS        = 17;
  localparam int TEXT_STRIDE = 64;
  localparam int SCREEN_W    = COLS * CHAR_W;
  localparam int SCREEN_H    = ROWS * CHAR_H;

  localparam int TEXT_AW = 12;
  localparam int FONT_AW = 12;
  localparam int RGB_W   = 16;

  typedef logic [RGB_W-1:0] rgb565_t;

  // Timing-generator controls travelling alongside each pixel.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/font_rom.sv
// 256-glyph x 16-row font store with a registered read; behavioural stand-in for the Gowin pROM.
module font_rom (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [11:0] addr,
  output logic [7:0]  data
);

  // Only a handful of glyphs are populated; every other code renders blank.
  function automatic logic [7:0] glyph_row(input logic [7:0] code, input logic [3:0] row);
    logic [7:0] bits;
    bits = 8'h00;
    case (code)
      8'h41: begin
        case (row)
          4'd3:  bits = 8'h18;
          4'd4:  bits = 8'h3C;
          4'd5,
          4'd6,
          4'd7:  bits = 8'h66;
          4'd8:  bits = 8'h7E;
          4'd9,
          4'd10,
          4'd11,
          4'd12: bits = 8'h66;
          default: bits = 8'h00;
        endcase
      end
      8'hDB:   bits = 8'hFF;
      default: bits = 8'h00;
    endcase
    return bits;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= 8'h00;
    end else if (ce) begin
      data <= glyph_row(addr[11:4], addr[3:0]);
    end
  end

endmodule

// File: rtl/text_renderer.sv
// 60x17 character-cell renderer for a 480x272 RGB565 LCD with a blinking cursor, 3-clk pipeline.
module text_renderer
  import text_pkg::*;
#(
  parameter rgb565_t     FG_COLOR     = 16'hFFFF,
  parameter rgb565_t     BG_COLOR     = 16'h0000,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [9:0]    pix_x,
  input  logic [8:0]    pix_y,
  input  logic          de_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [5:0]    cursor_col,
  input  logic [4:0]    cursor_row,
  input  logic          cursor_en,
  output logic [11:0]   text_ad,
  output logic          text_ce,
  input  logic [7:0]    text_dout,
  output rgb565_t       rgb,
  output logic          de_out,
  output logic          hs_out,
  output logic          vs_out
);

  localparam logic [5:0] COL_LIMIT = 6'(COLS);
  localparam logic [4:0] ROW_LIMIT = 5'(ROWS);
  localparam logic [7:0] FRAME_MAX = 8'(BLINK_FRAMES - 1);

  logic [5:0] cell_col;
  logic [4:0] cell_row;
  logic       cursor_hit;
  logic       unused_pix_x;

  logic [3:0] sub_y1;
  logic [2:0] sub_x1, sub_x2;
  logic       hit1, hit2;
  sync_t      sync1, sync2, sync3;

  logic [FONT_AW-1:0] font_addr;
  logic [7:0]         font_byte;

  logic       vs_q;
  logic [7:0] frame_cnt;
  logic       blink_phase;

  logic    pix_on;
  rgb565_t pix_color;
  rgb565_t rgb_next;

  // Cycle 0: cell lookup straight from the timing generator.
  assign cell_col     = pix_x[8:3];
  assign cell_row     = pix_y[8:4];
  assign unused_pix_x = pix_x[9];
  assign text_ad      = {1'b0, cell_row, cell_col};
  assign text_ce      = de_in & reset_n;

  // Out-of-range cursor positions can never match a visible cell.
  assign cursor_hit = cursor_en && (cursor_col == cell_col) && (cursor_row == cell_row)
                      && (cursor_col < COL_LIMIT) && (cursor_row < ROW_LIMIT);

  // Cycle 1: character code arrives from text RAM and forms the glyph row address.
  assign font_addr = {text_dout, sub_y1};

  font_rom u_font_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (sync1.de),
    .addr    (font_addr),
    .data    (font_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_y1 <= '0;
      sub_x1 <= '0;
      hit1   <= 1'b0;
      sync1  <= '0;
      sub_x2 <= '0;
      hit2   <= 1'b0;
      sync2  <= '0;
      sync3  <= '0;
      rgb    <= '0;
    end else begin
      sub_y1 <= pix_y[3:0];
      sub_x1 <= pix_x[2:0];
      hit1   <= cursor_hit;
      sync1  <= '{de: de_in, hs: hs_in, vs: vs_in};
      sub_x2 <= sub_x1;
      hit2   <= hit1;
      sync2  <= sync1;
      sync3  <= sync2;
      rgb    <= rgb_next;
    end
  end

  // Cycle 2: font byte is valid; MSB is the leftmost pixel of the cell.
  always_comb begin
    pix_on    = font_byte[3'd7 - sub_x2];
    pix_color = pix_on ? FG_COLOR : BG_COLOR;
    if (hit2 && blink_phase) begin
      pix_color = ~pix_color;
    end
    rgb_next = sync2.de ? pix_color : '0;
  end

  assign de_out = sync3.de;
  assign hs_out = sync3.hs;
  assign vs_out = sync3.vs;

  // Frame counter advances on each vs rising edge; blink half-period is BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q        <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vs_q <= vs_in;
      if (vs_in && !vs_q) begin
        if (frame_cnt == FRAME_MAX) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: vector table plus reset, cursor-blink and sync-delay sequences.
module tb_text_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        de_in, hs_in, vs_in;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_en;
  logic [11:0] text_ad;
  logic        text_ce;
  logic [7:0]  text_dout;
  logic [15:0] rgb;
  logic        de_out, hs_out, vs_out;

  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;

  text_renderer #(
    .FG_COLOR     (16'hFFFF),
    .BG_COLOR     (16'h0000),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .de_in      (de_in),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .cursor_en  (cursor_en),
    .text_ad    (text_ad),
    .text_ce    (text_ce),
    .text_dout  (text_dout),
    .rgb        (rgb),
    .de_out     (de_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out)
  );

  // Clock and external text RAM (registered read, one clk latency)
  always #5 clk = ~clk;

  logic [7:0] text_mem [4096];
  always @(posedge clk) begin
    if (text_ce) text_dout <= text_mem[text_ad];
  end

  // Scoreboard: {de, hs, vs, rgb} expected 3 clk after drive
  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one pixel at posedge+1, advance a clock, compare the output due now.
  task automatic step(input logic [9:0] x, input logic [8:0] y, input logic de,
                      input logic hs, input logic vs, input logic [15:0] exp_rgb,
                      input string tag);
    logic [18:0] e;
    string       t;
    pix_x = x; pix_y = y; de_in = de; hs_in = hs; vs_in = vs;
    exp_q.push_back({de, hs, vs, exp_rgb});
    tag_q.push_back(tag);
    @(posedge clk); #1;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".rgb"}, {16'h0, rgb}, {16'h0, e[15:0]});
      check({t, ".de"}, {31'h0, de_out}, {31'h0, e[18]});
      check({t, ".hs"}, {31'h0, hs_out}, {31'h0, e[17]});
      check({t, ".vs"}, {31'h0, vs_out}, {31'h0, e[16]});
    end
  endtask

  // After reset the two outputs still in flight must be all zero.
  task automatic start_stream();
    exp_q.delete();
    tag_q.delete();
    repeat (2) begin
      exp_q.push_back(19'h0);
      tag_q.push_back("post_reset");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'd100, 9'd100, 1'b0, 1'b0, 1'b0, BG, "idle");
  endtask

  task automatic vs_pulse();
    step(10'd100, 9'd100, 1'b0, 1'b0, 1'b1, BG, "vs_hi");
    step(10'd100, 9'd100, 1'b0, 1'b0, 1'b0, BG, "vs_lo");
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        de;
    logic        hs;
    logic [15:0] exp_rgb;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [9:0] x, input logic [8:0] y, input logic de,
                         input logic hs, input logic [15:0] exp_rgb);
    vec_t v;
    v.x = x; v.y = y; v.de = de; v.hs = hs; v.exp_rgb = exp_rgb;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) text_mem[i] = 8'h00;
    text_mem[0]      = 8'h41;
    text_mem[1]      = 8'h20;
    text_mem[12'h43B] = 8'hDB;
    text_dout  = 8'h00;

    // Reset state, with the timing generator already active
    reset_n = 1'b0;
    pix_x = 10'd3; pix_y = 9'd3; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    cursor_col = 6'd0; cursor_row = 5'd0; cursor_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.rgb", {16'h0, rgb}, 32'h0);
    check("reset.de_out", {31'h0, de_out}, 32'h0);
    check("reset.hs_out", {31'h0, hs_out}, 32'h0);
    check("reset.vs_out", {31'h0, vs_out}, 32'h0);
    check("reset.text_ce", {31'h0, text_ce}, 32'h0);
    hs_in = 1'b0; vs_in = 1'b0;
    reset_n = 1'b1;
    start_stream();

    // Combinational text RAM address and enable
    pix_x = 10'd0;   pix_y = 9'd0;   de_in = 1'b1; #1;
    check("text_ad.origin", {20'h0, text_ad}, 32'h000);
    check("text_ce.de1", {31'h0, text_ce}, 32'h1);
    pix_x = 10'd8;   pix_y = 9'd16;  de_in = 1'b0; #1;
    check("text_ad.cell_1_1", {20'h0, text_ad}, 32'h041);
    check("text_ce.de0", {31'h0, text_ce}, 32'h0);
    pix_x = 10'd479; pix_y = 9'd271; #1;
    check("text_ad.last_cell", {20'h0, text_ad}, 32'h43B);
    pix_x = 10'd600; pix_y = 9'd300; #1;
    check("text_ad.offscreen", {20'h0, text_ad}, {20'h0, 2'b0, 5'd18, 6'd11});
    @(posedge clk); #1;

    // Vector table: 'A' rows, block glyph at the last cell, blanking
    add_vec(10'd0, 9'd3, 1'b1, 1'b0, BG);
    add_vec(10'd1, 9'd3, 1'b1, 1'b0, BG);
    add_vec(10'd2, 9'd3, 1'b1, 1'b1, BG);
    add_vec(10'd3, 9'd3, 1'b1, 1'b1, FG);
    add_vec(10'd4, 9'd3, 1'b1, 1'b0, FG);
    add_vec(10'd5, 9'd3, 1'b1, 1'b0, BG);
    add_vec(10'd6, 9'd3, 1'b1, 1'b1, BG);
    add_vec(10'd7, 9'd3, 1'b1, 1'b0, BG);
    add_vec(10'd0, 9'd8, 1'b1, 1'b0, BG);
    add_vec(10'd1, 9'd8, 1'b1, 1'b0, FG);
    add_vec(10'd7, 9'd8, 1'b1, 1'b0, BG);
    add_vec(10'd6, 9'd8, 1'b1, 1'b0, FG);
    add_vec(10'd3, 9'd0, 1'b1, 1'b0, BG);
    add_vec(10'd3, 9'd15, 1'b1, 1'b0, BG);
    add_vec(10'd3, 9'd3, 1'b0, 1'b0, BG);
    add_vec(10'd472, 9'd271, 1'b1, 1'b0, FG);
    add_vec(10'd479, 9'd271, 1'b1, 1'b1, FG);
    add_vec(10'd475, 9'd256, 1'b1, 1'b0, FG);
    add_vec(10'd479, 9'd271, 1'b0, 1'b0, BG);
    add_vec(10'd600, 9'd3, 1'b0, 1'b1, BG);
    add_vec(10'd8, 9'd3, 1'b1, 1'b0, BG);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].hs, 1'b0, vecs[i].exp_rgb,
           $sformatf("vec%0d", i));
    end
    idle(3);

    // Reset mid-line while de=1, outputs must clear without a clock
    for (int i = 0; i < 4; i++) step(10'd3, 9'd3, 1'b1, 1'b0, 1'b0, FG, "pre_reset");
    #2 reset_n = 1'b0;
    #1;
    check("midreset.rgb", {16'h0, rgb}, 32'h0);
    check("midreset.de_out", {31'h0, de_out}, 32'h0);
    check("midreset.text_ce", {31'h0, text_ce}, 32'h0);
    @(posedge clk); #1;
    check("midreset.rgb_held", {16'h0, rgb}, 32'h0);
    reset_n = 1'b1;
    start_stream();
    step(10'd3, 9'd3, 1'b1, 1'b0, 1'b0, FG, "after_reset0");
    step(10'd4, 9'd3, 1'b1, 1'b0, 1'b0, FG, "after_reset1");
    step(10'd5, 9'd3, 1'b1, 1'b0, 1'b0, BG, "after_reset2");
    step(10'd3, 9'd3, 1'b1, 1'b0, 1'b0, FG, "after_reset3");
    idle(3);

    // Cursor blink: phase starts at 0, toggles after 2 vs rising edges
    cursor_en = 1'b1; cursor_col = 6'd1; cursor_row = 5'd0;
    step(10'd8, 9'd0, 1'b1, 1'b0, 1'b0, BG, "cursor_phase0");
    idle(3);
    vs_pulse();
    step(10'd8, 9'd0, 1'b1, 1'b0, 1'b0, BG, "cursor_one_edge");
    idle(3);
    vs_pulse();
    idle(3);
    step(10'd8, 9'd0, 1'b1, 1'b0, 1'b0, FG, "cursor_on_left");
    step(10'd15, 9'd5, 1'b1, 1'b0, 1'b0, FG, "cursor_on_right");
    step(10'd0, 9'd0, 1'b1, 1'b0, 1'b0, BG, "cursor_prev_cell");
    step(10'd16, 9'd0, 1'b1, 1'b0, 1'b0, BG, "cursor_next_cell");
    step(10'd8, 9'd16, 1'b1, 1'b0, 1'b0, BG, "cursor_next_row");
    step(10'd8, 9'd0, 1'b0, 1'b0, 1'b0, BG, "cursor_blank");
    cursor_col = 6'd0;
    step(10'd3, 9'd3, 1'b1, 1'b0, 1'b0, BG, "cursor_on_A_set");
    step(10'd0, 9'd3, 1'b1, 1'b0, 1'b0, FG, "cursor_on_A_clr");
    cursor_col = 6'd59;
    step(10'd472, 9'd0, 1'b1, 1'b0, 1'b0, FG, "cursor_col59");
    cursor_col = 6'd60;
    for (int x = 0; x < 480; x++) begin
      step(10'(x), 9'd3, 1'b1, 1'b0, 1'b0, (x == 3 || x == 4) ? FG : BG, "cursor_col60");
    end
    cursor_col = 6'd1; cursor_row = 5'd17;
    step(10'd8, 9'd0, 1'b1, 1'b0, 1'b0, BG, "cursor_row17");
    cursor_row = 5'd0;
    idle(3);
    vs_pulse();
    vs_pulse();
    idle(3);
    step(10'd8, 9'd0, 1'b1, 1'b0, 1'b0, BG, "cursor_reverted");
    idle(3);

    // Random sync pattern over a blank cell
    cursor_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(10'd100, 9'd100, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), BG, "sync");
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
